// File: rtl/exe_stage_md.sv
// Execute stage with a multi-cycle multiply/divide unit, HI/LO registers, store byte-enables
// and a forwarding bus that reports whether the forwarded value is already final.
module exe_stage_md #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned PC_W    = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [3:0]          in_md_op,
  input  logic [DATA_W-1:0]   in_src1,
  input  logic [DATA_W-1:0]   in_src2,
  input  logic [DATA_W-1:0]   in_alu_result,
  input  logic                in_load_op,
  input  logic                in_mem_we,
  input  logic [1:0]          in_mem_size,
  input  logic                in_gr_we,
  input  logic [4:0]          in_dest,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic                es_res_from_mem,
  output logic                es_gr_we,
  output logic [4:0]          es_dest,
  output logic [DATA_W-1:0]   es_result,
  output logic [PC_W-1:0]     es_pc,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_wen,
  output logic [DATA_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  output logic                fwd_valid,
  output logic [4:0]          fwd_dest,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                fwd_ready
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned NH      = DATA_W / 16;
  localparam int unsigned AW      = $clog2(NB);
  localparam int unsigned CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  logic                r_es_valid;
  logic [3:0]          r_md_op;
  logic [DATA_W-1:0]   r_src1, r_src2, r_alu_result;
  logic                r_load_op, r_mem_we, r_gr_we;
  logic [1:0]          r_mem_size;
  logic [4:0]          r_dest;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_hi, r_lo, r_rem, r_quo;
  state_e              r_state;
  logic [CW-1:0]       r_cnt;

  logic [3:0]          w_op_in;
  logic                w_in_mul, w_in_div, w_is_md, w_ready_go, w_accept, w_leave;
  logic                w_mul_sgn, w_div_sgn, w_q_neg, w_r_neg, w_q_bit;
  logic [DATA_W-1:0]   w_dvd_abs, w_dvs_abs, w_rem_nx, w_quo_nx, w_div_hi, w_div_lo;
  logic [DATA_W:0]     w_rem_sh, w_sub;
  logic [2*DATA_W-1:0] w_mul_a, w_mul_b, w_prod;
  logic [AW-1:0]       w_a;

  assign w_op_in    = (in_md_op > 4'd8) ? 4'd0 : in_md_op;
  assign w_in_mul   = (w_op_in == 4'd1) || (w_op_in == 4'd2);
  assign w_in_div   = (w_op_in == 4'd3) || (w_op_in == 4'd4);
  assign w_is_md    = (r_md_op != 4'd0) && (r_md_op <= 4'd4);
  assign w_ready_go = !w_is_md || (r_state == StDone);
  assign es_allowin = resetn & (!r_es_valid | (w_ready_go & ms_allowin));
  assign w_accept   = ds_to_es_valid & es_allowin;
  assign w_leave    = es_to_ms_valid & ms_allowin;

  // Multiply: extend to 2*DATA_W so one truncated product covers signed and unsigned.
  assign w_mul_sgn = (r_md_op == 4'd1);
  assign w_mul_a   = {{DATA_W{w_mul_sgn & r_src1[DATA_W-1]}}, r_src1};
  assign w_mul_b   = {{DATA_W{w_mul_sgn & r_src2[DATA_W-1]}}, r_src2};
  assign w_prod    = w_mul_a * w_mul_b;

  // Restoring divide on magnitudes; signs are reapplied when the result is written.
  assign w_dvd_abs = ((w_op_in == 4'd3) && in_src1[DATA_W-1]) ? -in_src1 : in_src1;
  assign w_div_sgn = (r_md_op == 4'd3);
  assign w_dvs_abs = (w_div_sgn && r_src2[DATA_W-1]) ? -r_src2 : r_src2;
  assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
  assign w_sub     = w_rem_sh - {1'b0, w_dvs_abs};
  assign w_q_bit   = !w_sub[DATA_W];
  assign w_rem_nx  = w_q_bit ? w_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_nx  = {r_quo[DATA_W-2:0], w_q_bit};
  assign w_q_neg   = w_div_sgn & (r_src1[DATA_W-1] ^ r_src2[DATA_W-1]);
  assign w_r_neg   = w_div_sgn & r_src1[DATA_W-1];
  assign w_div_lo  = (r_src2 == '0) ? '1     : (w_q_neg ? -w_quo_nx : w_quo_nx);
  assign w_div_hi  = (r_src2 == '0) ? r_src1 : (w_r_neg ? -w_rem_nx : w_rem_nx);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
    end else begin
      if (w_accept && w_in_mul) begin
        r_state <= StMul;
        r_cnt   <= '0;
      end else if (w_accept && w_in_div) begin
        r_state <= StDiv;
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_dvd_abs;
      end else begin
        case (r_state)
          StMul: begin
            if (r_cnt == CW'(MUL_LAT - 1)) begin
              r_state      <= StDone;
              {r_hi, r_lo} <= w_prod;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          StDiv: begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (r_cnt == CW'(DATA_W - 1)) begin
              r_state <= StDone;
              r_hi    <= w_div_hi;
              r_lo    <= w_div_lo;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          StDone:  if (ms_allowin) r_state <= StIdle;
          default: ;
        endcase
      end
      if (w_leave && (r_md_op == 4'd7)) r_hi <= r_src1;
      if (w_leave && (r_md_op == 4'd8)) r_lo <= r_src1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_es_valid   <= 1'b0;
      r_md_op      <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_alu_result <= '0;
      r_load_op    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_size   <= '0;
      r_gr_we      <= 1'b0;
      r_dest       <= '0;
      r_pc         <= '0;
    end else if (w_accept) begin
      r_es_valid   <= 1'b1;
      r_md_op      <= w_op_in;
      r_src1       <= in_src1;
      r_src2       <= in_src2;
      r_alu_result <= in_alu_result;
      r_load_op    <= in_load_op;
      r_mem_we     <= in_mem_we;
      r_mem_size   <= in_mem_size;
      r_gr_we      <= in_gr_we;
      r_dest       <= in_dest;
      r_pc         <= in_pc;
    end else if (w_leave) begin
      r_es_valid <= 1'b0;
    end
  end

  assign es_to_ms_valid  = r_es_valid & w_ready_go;
  assign es_res_from_mem = r_load_op;
  assign es_gr_we        = r_gr_we;
  assign es_dest         = r_dest;
  assign es_pc           = r_pc;

  always_comb begin
    case (r_md_op)
      4'd5:    es_result = r_hi;
      4'd6:    es_result = r_lo;
      default: es_result = r_alu_result;
    endcase
  end

  assign data_sram_en   = 1'b1;
  assign data_sram_addr = r_alu_result;
  assign w_a            = r_alu_result[AW-1:0];

  always_comb begin
    data_sram_wen   = '0;
    data_sram_wdata = r_src2;
    case (r_mem_size)
      2'd0: begin
        data_sram_wen   = NB'(1) << w_a;
        data_sram_wdata = {NB{r_src2[7:0]}};
      end
      2'd1: begin
        if (!w_a[0]) data_sram_wen = NB'(3) << w_a;
        data_sram_wdata = {NH{r_src2[15:0]}};
      end
      default: if (w_a == '0) data_sram_wen = '1;
    endcase
    if (!(r_es_valid && r_mem_we)) data_sram_wen = '0;
  end

  assign fwd_valid = r_es_valid & r_gr_we & (r_dest != 5'd0);
  assign fwd_dest  = r_dest;
  assign fwd_data  = es_result;
  assign fwd_ready = r_es_valid & !r_load_op & !w_is_md;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: scoreboard of expected results per issued instruction,
// plus timing, store byte-enable, stall and reset checks.
module tb_exe_stage_md;

  logic        clk, resetn, ds_to_es_valid, es_allowin;
  logic [3:0]  in_md_op;
  logic [31:0] in_src1, in_src2, in_alu_result, in_pc;
  logic        in_load_op, in_mem_we, in_gr_we, ms_allowin;
  logic [1:0]  in_mem_size;
  logic [4:0]  in_dest, es_dest, fwd_dest;
  logic        es_to_ms_valid, es_res_from_mem, es_gr_we, data_sram_en, fwd_valid, fwd_ready;
  logic [31:0] es_result, es_pc, data_sram_addr, data_sram_wdata, fwd_data;
  logic [3:0]  data_sram_wen;

  exe_stage_md dut (
    .clk(clk), .resetn(resetn), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .in_md_op(in_md_op), .in_src1(in_src1), .in_src2(in_src2), .in_alu_result(in_alu_result),
    .in_load_op(in_load_op), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .in_pc(in_pc), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_res_from_mem(es_res_from_mem), .es_gr_we(es_gr_we),
    .es_dest(es_dest), .es_result(es_result), .es_pc(es_pc), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_ready(fwd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a, b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a, b);
    longint sa, sb, q, r;
    logic [63:0] qq, rr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qq = q;
    rr = r;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Drives one instruction, waits (bounded) for acceptance and records its expected result.
  task automatic issue(input logic [3:0] op, input logic [31:0] s1, s2, alu, input logic ld,
                       input logic we, input logic [1:0] sz, input logic gw,
                       input logic [4:0] dst, input logic [31:0] pc);
    int n = 0;
    logic [3:0] eop;
    exp_t e;
    in_md_op = op; in_src1 = s1; in_src2 = s2; in_alu_result = alu; in_load_op = ld;
    in_mem_we = we; in_mem_size = sz; in_gr_we = gw; in_dest = dst; in_pc = pc;
    ds_to_es_valid = 1'b1;
    #1;
    while (!es_allowin && n < 100) begin
      step();
      n++;
    end
    if (!es_allowin) begin
      chk("accept_timeout", 64'(es_allowin), 1);
      ds_to_es_valid = 1'b0;
      return;
    end
    step();
    ds_to_es_valid = 1'b0;
    eop = (op > 4'd8) ? 4'd0 : op;
    e.res = alu;
    e.pc  = pc;
    case (eop)
      4'd1: {m_hi, m_lo} = mul_model(1'b1, s1, s2);
      4'd2: {m_hi, m_lo} = mul_model(1'b0, s1, s2);
      4'd3: {m_hi, m_lo} = div_model(1'b1, s1, s2);
      4'd4: {m_hi, m_lo} = div_model(1'b0, s1, s2);
      4'd5: e.res = m_hi;
      4'd6: e.res = m_lo;
      4'd7: m_hi = s1;
      4'd8: m_lo = s1;
      default: ;
    endcase
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb_q.size()), 0);
  endtask

  // Scoreboard check on every transfer to the memory stage.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && es_to_ms_valid && ms_allowin) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", 64'(sb_q.size()), 1);
      end else begin
        e = sb_q.pop_front();
        chk("es_result", es_result, e.res);
        chk("es_pc", es_pc, e.pc);
      end
    end
  end

  logic [3:0]  md_op [8]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd3, 4'd3, 4'd4};
  logic [31:0] md_a  [8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd100};
  logic [31:0] md_b  [8]  = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd7};
  logic [1:0]  st_sz [7]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3};
  logic [31:0] st_ad [7]  = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1002, 32'h1000,
                              32'h2000};
  logic [31:0] st_d  [7]  = '{32'hAB, 32'h1234, 32'h1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                              32'h1C5, 32'h0102_0304};
  logic [3:0]  st_wen [7] = '{4'b1000, 4'b0000, 4'b1100, 4'b1111, 4'b0000, 4'b0001, 4'b1111};
  logic [31:0] st_wd [7]  = '{32'hABAB_ABAB, 32'h1234_1234, 32'h1234_1234, 32'hDEAD_BEEF,
                              32'hDEAD_BEEF, 32'hC5C5_C5C5, 32'h0102_0304};

  initial begin
    int n;
    logic [31:0] held;
    resetn = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
    in_md_op = '0; in_src1 = '0; in_src2 = '0; in_alu_result = '0; in_pc = '0;
    in_load_op = 1'b0; in_mem_we = 1'b0; in_mem_size = '0; in_gr_we = 1'b0; in_dest = '0;
    repeat (3) step();
    chk("rst_to_ms_valid", 64'(es_to_ms_valid), 0);
    chk("rst_allowin", 64'(es_allowin), 0);
    chk("rst_result", es_result, 0);
    chk("rst_sram_en", 64'(data_sram_en), 1);
    chk("rst_wen", 64'(data_sram_wen), 0);
    chk("rst_fwd", {fwd_valid, fwd_ready}, 0);
    resetn = 1'b1;
    step();
    chk("allowin_idle", 64'(es_allowin), 1);

    // Simple op: result and forwarding visible one cycle after accept.
    issue(4'd0, 0, 0, 32'h1234, 0, 0, 2'd2, 1, 5'd5, 32'h100);
    chk("add_valid", 64'(es_to_ms_valid), 1);
    chk("add_result", es_result, 32'h1234);
    chk("add_fwd", {fwd_valid, fwd_ready, fwd_dest, fwd_data}, {2'b11, 5'd5, 32'h1234});
    step();
    chk("add_gone", 64'(es_to_ms_valid), 0);
    issue(4'd0, 0, 0, 32'h55, 0, 0, 2'd2, 1, 5'd0, 32'h104);
    chk("dest0_fwd_valid", 64'(fwd_valid), 0);
    issue(4'd12, 32'h9, 32'h9, 32'h77, 0, 0, 2'd2, 1, 5'd6, 32'h108);
    chk("op12_ready", {es_to_ms_valid, fwd_ready}, 2'b11);
    issue(4'd0, 0, 0, 32'h200, 1, 0, 2'd2, 1, 5'd3, 32'h10C);
    chk("load_fwd", {es_res_from_mem, fwd_ready}, 2'b10);
    drain();

    // Multiply/divide followed by MFHI and MFLO, with latency check.
    for (int i = 0; i < 8; i++) begin
      issue(md_op[i], md_a[i], md_b[i], 32'h300 + 32'(i), 0, 0, 2'd2, 0, 5'd0, 32'h200 + 32'(i));
      chk("md_fwd_ready", 64'(fwd_ready), 0);
      n = 0;
      while (!es_to_ms_valid && n < 100) begin
        step();
        n++;
      end
      chk("md_latency", 64'(n), (md_op[i] <= 4'd2) ? 2 : 32);
      issue(4'd5, 0, 0, 0, 0, 0, 2'd2, 1, 5'd8, 32'h280 + 32'(i));
      chk("mfhi_fwd_ready", 64'(fwd_ready), 1);
      issue(4'd6, 0, 0, 0, 0, 0, 2'd2, 1, 5'd9, 32'h2C0 + 32'(i));
      drain();
    end

    // MTHI/MTLO then read back.
    issue(4'd7, 32'hCAFE_0001, 0, 32'h11, 0, 0, 2'd2, 0, 5'd0, 32'h400);
    issue(4'd8, 32'hBEEF_0002, 0, 32'h12, 0, 0, 2'd2, 0, 5'd0, 32'h404);
    issue(4'd5, 0, 0, 0, 0, 0, 2'd2, 1, 5'd8, 32'h408);
    issue(4'd6, 0, 0, 0, 0, 0, 2'd2, 1, 5'd9, 32'h40C);
    drain();

    // Store byte-enables and replicated write data.
    for (int i = 0; i < 7; i++) begin
      issue(4'd0, 0, st_d[i], st_ad[i], 0, 1, st_sz[i], 0, 5'd0, 32'h500 + 32'(i));
      chk("st_wen", 64'(data_sram_wen), 64'(st_wen[i]));
      chk("st_wdata", data_sram_wdata, st_wd[i]);
      chk("st_addr", data_sram_addr, st_ad[i]);
      step();
      chk("st_wen_idle", 64'(data_sram_wen), 0);
    end

    // DIV finishing while memory stage is blocked.
    issue(4'd3, 32'd100, 32'd7, 32'hABC, 0, 0, 2'd2, 0, 5'd0, 32'h600);
    ms_allowin = 1'b0;
    n = 0;
    while (!es_to_ms_valid && n < 100) begin
      step();
      n++;
    end
    chk("stall_latency", 64'(n), 32);
    held = es_result;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {es_to_ms_valid, es_allowin, held}, {2'b10, 32'hABC});
      chk("stall_result", es_result, 32'hABC);
    end
    ms_allowin = 1'b1;
    issue(4'd5, 0, 0, 0, 0, 0, 2'd2, 1, 5'd8, 32'h604);
    issue(4'd6, 0, 0, 0, 0, 0, 2'd2, 1, 5'd9, 32'h608);
    drain();

    // Reset in the middle of a divide aborts it and clears HI/LO.
    issue(4'd3, 32'd1000, 32'd3, 32'h700, 0, 0, 2'd2, 0, 5'd0, 32'h700);
    repeat (9) step();
    resetn = 1'b0;
    step();
    chk("midrst_valid", {es_to_ms_valid, es_allowin, fwd_valid}, 0);
    chk("midrst_result", es_result, 0);
    sb_q.delete();
    m_hi = 0;
    m_lo = 0;
    resetn = 1'b1;
    step();
    issue(4'd5, 0, 0, 0, 0, 0, 2'd2, 1, 5'd8, 32'h710);
    issue(4'd6, 0, 0, 0, 0, 0, 2'd2, 1, 5'd9, 32'h714);
    issue(4'd1, 32'd3, 32'd5, 32'h33, 0, 0, 2'd2, 0, 5'd0, 32'h718);
    issue(4'd6, 0, 0, 0, 0, 0, 2'd2, 1, 5'd9, 32'h71C);
    issue(4'd5, 0, 0, 0, 0, 0, 2'd2, 1, 5'd8, 32'h720);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage_md.md
Name: exe_stage_md

Overview:
- Parametrised execute stage for the 5-stage pipeline, sitting between the decode stage and the memory stage.
- Adds a multi-cycle multiply/divide unit with HI/LO registers, MFHI/MFLO/MTHI/MTLO, and sub-word store byte-enables.
- Extends the forward/block bus with a "data ready" flag so decode can stall on results that are not yet available.
- Simple ALU ops and address generation come from a shared combinational ALU in the parent via in_alu_result.

Parameters:
- DATA_W, 32, datapath width (must be a multiple of 8, ≥16).
- MUL_LAT, 2, cycles spent in MUL state (≥1).
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ds_to_es_valid  in  1  decode has an instruction
- es_allowin  out  1  stage can accept
- in_md_op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as 0
- in_src1  in  DATA_W  rs value
- in_src2  in  DATA_W  rt value
- in_alu_result  in  DATA_W  ALU result or memory address
- in_load_op  in  1  load instruction
- in_mem_we  in  1  store instruction
- in_mem_size  in  2  0 byte, 1 half, 2 word, 3 word
- in_gr_we  in  1  writes the register file
- in_dest  in  5  destination register
- in_pc  in  PC_W  instruction PC
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  result valid to memory stage
- es_res_from_mem  out  1  registered in_load_op
- es_gr_we  out  1  registered in_gr_we
- es_dest  out  5  registered in_dest
- es_result  out  DATA_W  final result
- es_pc  out  PC_W  registered PC
- data_sram_en  out  1  constant 1
- data_sram_wen  out  DATA_W/8  byte enables
- data_sram_addr  out  DATA_W  in_alu_result (registered copy)
- data_sram_wdata  out  DATA_W  replicated store data
- fwd_valid  out  1  es_valid & gr_we & dest≠0
- fwd_dest  out  5  es_dest
- fwd_data  out  DATA_W  es_result
- fwd_ready  out  1  fwd_data is final this cycle

Behaviour:
- All inputs are captured into stage registers on ds_to_es_valid & es_allowin.
- es_allowin = !es_valid | (es_ready_go & ms_allowin).
- es_to_ms_valid = es_valid & es_ready_go.
- Reset (resetn=0 at edge):
  - es_valid=0, HI=LO=0, state=IDLE, counter=0.
  - All outputs 0 except data_sram_en=1.
  - Reset mid-operation aborts it; HI/LO are not updated.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL when accepting op 1/2; IDLE→DIV when accepting op 3/4; counter cleared on entry.
  - MUL stays MUL_LAT cycles → DONE.
  - DIV stays DATA_W cycles (radix-2 restoring, one quotient bit per cycle) → DONE.
  - Entry into DONE writes HI/LO exactly once.
  - DONE → IDLE when ms_allowin=1; a new instruction may be accepted that same edge.
- es_ready_go = 1 for non-MULT/DIV ops; for ops 1-4 it is 1 only in DONE.
- MULT/MULTU: {HI,LO} = signed/unsigned 2·DATA_W product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN/−1: LO = MIN, HI = 0.
- es_result selection:
  - MFHI → HI; MFLO → LO (values at execute time, including an update made by the immediately preceding MULT/DIV).
  - All other ops → in_alu_result.
- MTHI/MTLO write HI/LO at the edge where the instruction leaves (es_to_ms_valid & ms_allowin).
- Stores, with a = addr[1:0]:
  - byte: wen = 1<<a, wdata = byte replicated.
  - half: wen = 0011 when a=0, 1100 when a=2, 0 otherwise (misaligned), wdata = half replicated.
  - word: wen = all ones only when a=0.
  - wen is forced to 0 unless es_valid.
  - For DATA_W≠32, generalise by the low log2(DATA_W/8) address bits.
- fwd_ready = !(in_load_op) & !(ops 1-4); MFHI/MFLO are ready.

Test Plan:
- ADD-like op, in_alu_result=0x1234, ms_allowin=1 → es_to_ms_valid 1 cycle after accept, es_result=0x1234, fwd_ready=1.
- MULT src1=0xFFFFFFFF, src2=2 (MUL_LAT=2) → es_to_ms_valid exactly 3 cycles after accept; following MFHI gives 0xFFFFFFFF, MFLO gives 0xFFFFFFFE.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 32 DIV cycles; DIVU 7/0 → LO=0xFFFFFFFF, HI=7; DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Store byte at addr 0x..3 with rt=0xAB → wen=1000, wdata=0xABABABAB; store half at addr 0x..1 → wen=0000.
- DIV in DONE with ms_allowin=0 for 5 cycles → state, HI/LO and es_result held, es_allowin=0, HI/LO written once.
- resetn=0 at DIV cycle 10 → next cycle es_valid=0, HI=LO=0; a new MULT completes normally afterwards.
